// File: rtl/fifo_pkg.sv
// Shared widths and pointer/count types for the FIFO pointer/flag controller.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 4;
    localparam int unsigned FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

    typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [FIFO_ADDR_WIDTH:0]   cnt_t;

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Wrapping W-bit pointer register that steps by one when enabled.
module fifo_ptr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] ptr
);

    // Natural W-bit overflow gives the modulo-DEPTH wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns a register file with an async read port
// into a synchronous FIFO; data never passes through this block.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    // Flags decode occupancy only, never the current requests.
    always_comb begin
        full         = (cnt == CW'(DEPTH));
        empty        = (cnt == '0);
        almost_full  = (cnt >= CW'(AF_THRESH));
        almost_empty = (cnt <= CW'(AE_THRESH));
        count        = cnt;
    end

    // A push into a full FIFO is fine when a pop vacates the head slot the
    // same cycle; the read port is asynchronous so the old word is read first.
    // Holding wr_en low during reset keeps the stale array untouched.
    always_comb begin
        push_ok = wr & ~reset & (~full | rd);
        pop_ok  = rd & ~empty;
        wr_en   = push_ok;
    end

    fifo_ptr #(.W(ADDR_WIDTH)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .en    (push_ok),
        .ptr   (w_addr)
    );

    fifo_ptr #(.W(ADDR_WIDTH)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .en    (pop_ok),
        .ptr   (r_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // One-cycle error pulses for each rejected request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr & ~push_ok;
            underflow <= rd & ~pop_ok;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural register file alongside.
module tb_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [3:0] w_addr;
    logic [3:0] r_addr;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] mem [16];
    logic [7:0] data_out;

    int errors = 0;
    int checks = 0;

    fifo_ctrl #(.ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .wr_en        (wr_en),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous write, asynchronous read.
    always @(posedge clk) if (wr_en) mem[w_addr] <= din;
    assign data_out = mem[r_addr];

    task automatic check_reset_values(input string tag);
        checks++;
        if ({w_addr, r_addr} !== 8'h00) begin
            errors++; $display("FAIL %s addr: w=%0d r=%0d expected 0/0", tag, w_addr, r_addr);
        end
        checks++;
        if (count !== 5'd0) begin
            errors++; $display("FAIL %s count: got %0d expected 0", tag, count);
        end
        checks++;
        if ({wr_en, full, empty, almost_full, almost_empty, overflow, underflow} !== 7'b0010100) begin
            errors++;
            $display("FAIL %s flags {wr_en,full,empty,af,ae,ov,un}: got %b expected 0010100", tag,
                     {wr_en, full, empty, almost_full, almost_empty, overflow, underflow});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr = 1'b1; rd = 1'b0; din = 8'h00;
        repeat (2) @(posedge clk);
        #1 check_reset_values("reset_held");
        @(negedge clk);
        reset = 1'b0; wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_values("reset_idle");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr = 1'b1; rd = 1'b0; din = 8'(i);
            #1;
            checks++;
            if (wr_en !== 1'b1 || w_addr !== 4'(i)) begin
                errors++; $display("FAIL fill_wr_en[%0d]: wr_en=%b w_addr=%0d expected 1/%0d", i, wr_en, w_addr, i);
            end
            @(posedge clk); #1;
            checks++;
            if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i + 1 == 16)
                || almost_empty !== (i + 1 <= 2)) begin
                errors++;
                $display("FAIL fill_flags[%0d]: count=%0d af=%b full=%b ae=%b expected %0d/%b/%b/%b", i,
                         count, almost_full, full, almost_empty, i + 1, (i + 1 >= 14), (i + 1 == 16), (i + 1 <= 2));
            end
        end
        checks++;
        if (w_addr !== 4'd0 || empty !== 1'b0) begin
            errors++; $display("FAIL fill_wrap: w_addr=%0d empty=%b expected 0/0", w_addr, empty);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; din = 8'hEE;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL ovf_wr_en: got %b expected 0", wr_en);
        end
        @(posedge clk); #1;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || w_addr !== 4'd0 || full !== 1'b1) begin
            errors++; $display("FAIL ovf_pulse: ov=%b count=%0d w_addr=%0d full=%b expected 1/16/0/1",
                               overflow, count, w_addr, full);
        end
        @(negedge clk);
        wr = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_one_cycle: ov=%b expected 0", overflow);
        end
    endtask

    task automatic test_full_rw();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wr = 1'b1; rd = 1'b1; din = 8'h10 + 8'(k);
            #1;
            checks++;
            if (data_out !== 8'(k) || wr_en !== 1'b1 || w_addr !== 4'(k)) begin
                errors++; $display("FAIL full_rw_data[%0d]: data=%0h wr_en=%b w_addr=%0d expected %0h/1/%0d",
                                   k, data_out, wr_en, w_addr, k, k);
            end
            @(posedge clk); #1;
            checks++;
            if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
                errors++; $display("FAIL full_rw_count[%0d]: count=%0d full=%b ov=%b un=%b expected 16/1/0/0",
                                   k, count, full, overflow, underflow);
            end
        end
    endtask

    task automatic test_drain();
        logic [7:0] exp;
        logic [3:0] ra;
        for (int k = 0; k < 16; k++) begin
            exp = (k < 12) ? 8'(k + 4) : 8'h10 + 8'(k - 12);
            @(negedge clk);
            wr = 1'b0; rd = 1'b1;
            #1;
            checks++;
            if (data_out !== exp || r_addr !== 4'(k + 4)) begin
                errors++; $display("FAIL drain_data[%0d]: data=%0h r_addr=%0d expected %0h/%0d",
                                   k, data_out, r_addr, exp, 4'(k + 4));
            end
            @(posedge clk); #1;
            checks++;
            if (count !== 5'(15 - k) || almost_empty !== (15 - k <= 2) || almost_full !== (15 - k >= 14)) begin
                errors++; $display("FAIL drain_count[%0d]: count=%0d ae=%b af=%b expected %0d", k,
                                   count, almost_empty, almost_full, 15 - k);
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL drain_empty: empty=%b full=%b expected 1/0", empty, full);
        end
        ra = r_addr;
        @(negedge clk);
        rd = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (underflow !== 1'b1 || r_addr !== 4'd4 || count !== 5'd0) begin
            errors++; $display("FAIL udf_pulse: un=%b r_addr=%0d count=%0d expected 1/4/0", underflow, r_addr, count);
        end
        checks++;
        if (r_addr !== ra) begin
            errors++; $display("FAIL udf_rptr_hold: r_addr=%0d expected %0d", r_addr, ra);
        end
        @(negedge clk);
        rd = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (underflow !== 1'b0) begin
            errors++; $display("FAIL udf_one_cycle: un=%b expected 0", underflow);
        end
    endtask

    task automatic test_empty_wr_rd();
        @(negedge clk);
        wr = 1'b1; rd = 1'b1; din = 8'hA5;
        #1;
        checks++;
        if (wr_en !== 1'b1 || w_addr !== 4'd4) begin
            errors++; $display("FAIL empty_rw_wr_en: wr_en=%b w_addr=%0d expected 1/4", wr_en, w_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (underflow !== 1'b1 || count !== 5'd1 || empty !== 1'b0 || almost_empty !== 1'b1) begin
            errors++; $display("FAIL empty_rw_flags: un=%b count=%0d empty=%b ae=%b expected 1/1/0/1",
                               underflow, count, empty, almost_empty);
        end
        checks++;
        if (data_out !== 8'hA5 || r_addr !== 4'd4) begin
            errors++; $display("FAIL empty_rw_data: data=%0h r_addr=%0d expected a5/4", data_out, r_addr);
        end
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr = 1'b1; rd = 1'b0; din = 8'h50 + 8'(i);
            @(posedge clk);
        end
        @(negedge clk);
        wr = 1'b0;
        #1;
        checks++;
        if (count !== 5'd7 || w_addr !== 4'd11 || r_addr !== 4'd4) begin
            errors++; $display("FAIL pre_reset: count=%0d w=%0d r=%0d expected 7/11/4", count, w_addr, r_addr);
        end
        wr = 1'b1; rd = 1'b1;
        #1 reset = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        check_reset_values("async_reset_held");
        reset = 1'b0; wr = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        check_reset_values("post_reset");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_rw();
        test_drain();
        test_empty_wr_rd();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer/flag controller that turns a 2**ADDR_WIDTH x DATA_WIDTH register file into a synchronous FIFO.
  - The register file has a synchronous write port and an asynchronous read port.
- The block accepts push/pop requests and drives the file's w_addr, r_addr and wr_en.
- It reports occupancy, full/empty, watermark flags and one-cycle error pulses.
- It sits between the requesting logic and the storage array; data itself never passes through it.

Parameters:
- ADDR_WIDTH, 4: address width of the register file; DEPTH = 2**ADDR_WIDTH entries.
- AF_THRESH, 2**ADDR_WIDTH-2: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr  in  1  push request; data is presented to the register file's data_in by the requester.
- rd  in  1  pop request; the current head is on the register file's data_out this cycle.
- w_addr  out  ADDR_WIDTH  write pointer to the register file.
- r_addr  out  ADDR_WIDTH  read pointer to the register file.
- wr_en  out  1  qualified write enable to the register file.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a push was rejected.
- underflow  out  1  one-cycle pulse: a pop was rejected.

Behaviour:
- State: wptr, rptr (ADDR_WIDTH bits each), cnt (ADDR_WIDTH+1 bits), overflow/underflow registers.
  - All are cleared asynchronously on reset.
- Reset values:
  - w_addr=0, r_addr=0, wr_en=0 (wr is don't-care during reset), count=0.
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- w_addr=wptr and r_addr=rptr, both driven directly from registers.
- full, empty, almost_* and count are combinational decodes of cnt only, never of wr/rd.
- Accept rules, evaluated each cycle from the current flags:
  - push_ok = wr & (~full | rd).
  - pop_ok = rd & ~empty.
- wr_en = push_ok, combinational, so the register file writes at the same edge the pointer advances.
- At the rising edge:
  - push_ok: wptr <= wptr+1, wrapping modulo DEPTH.
  - pop_ok: rptr <= rptr+1, wrapping modulo DEPTH.
  - Occupancy update: cnt <= cnt + push_ok - pop_ok.
- Latency:
  - A pushed word is visible on data_out (via r_addr) one cycle after the push edge when the FIFO was empty.
  - Pop data is available in the same cycle rd is asserted.
- Boundary cases:
  - Full with wr&rd: both accepted; cnt stays DEPTH; the write targets the slot being vacated, which is legal because the read is asynchronous, pre-edge.
  - Full with wr only: rejected; overflow=1 for the following cycle; pointers unchanged.
  - Empty with wr&rd: only the push is accepted, with no fall-through; underflow=1 next cycle; cnt becomes 1.
  - Empty with rd only: rejected; underflow=1 next cycle.
  - Wrap-around: pointers roll DEPTH-1 -> 0 silently; full/empty come from cnt, never from pointer comparison.
  - Reset mid-operation: all state clears immediately; the register file contents are left stale and are treated as invalid.
- overflow/underflow are registered pulses, high for exactly one cycle per rejected request.
- Invariant: cnt == (wptr - rptr) mod DEPTH, or DEPTH when full. Both pointers are equal when cnt is 0 or DEPTH.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam-style defaults for ADDR_WIDTH and DEPTH.
  - typedef ptr_t (logic [ADDR_WIDTH-1:0]).
  - typedef cnt_t (logic [ADDR_WIDTH:0]).
- One natural sub-module, fifo_ptr: a wrapping ADDR_WIDTH-bit incrementer with an enable and asynchronous reset, instantiated twice (write and read).
- A top-level fifo wrapper instantiates fifo_ctrl plus the register file; it is outside this block.

Test Plan (ADDR_WIDTH=4, DEPTH=16, AF=14, AE=2):
- Reset, then idle -> empty=1, almost_empty=1, count=0, w_addr=r_addr=0, wr_en=0, no error pulses.
- 16 consecutive pushes of 0x00..0x0F -> wr_en high each cycle with w_addr 0..15; almost_full rises after push 14; full=1 and count=16 after push 16; w_addr wraps to 0.
- 17th push while full -> wr_en=0, overflow=1 for exactly one cycle, count stays 16.
- While full, wr&rd together for 4 cycles -> data_out reads 0x00..0x03 in order; new words written at addresses 0..3; count stays 16; full stays 1.
- Drain all 16 words -> data_out sequence is FIFO order, including the new words; empty=1 at the end; one further rd gives underflow pulse and r_addr unchanged.
- At empty, wr&rd together with data 0xA5 -> only the push is accepted; underflow pulse; next cycle count=1 and data_out=0xA5.
- Assert reset asynchronously mid-stream at count=7 -> all outputs return to reset values before the next clock edge.
